// File: rtl/cprv_arb_pkg.sv
// Shared types for the unified memory arbiter: requester IDs and slot FSM states.
package cprv_arb_pkg;

  localparam int unsigned CPRV_DATA_WIDTH = 64;

  typedef enum logic {REQ_D = 1'b0, REQ_I = 1'b1} req_id_t;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_BUSY = 1'b1} arb_state_t;

endpackage

// File: rtl/cprv_arb_id_fifo.sv
// In-order FIFO of requester IDs; the head names the owner of the next memory response.
module cprv_arb_id_fifo
  import cprv_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  req_id_t push_id_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output req_id_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  req_id_t       mem_q [DEPTH];
  req_id_t       mem_d [DEPTH];

  // Extra pointer bit tells a full wrap apart from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i && !full_o) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_id_i;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= REQ_D;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/cprv_mem_arbiter.sv
// Two-requester (D/I) arbiter onto one memory port with a registered request slot.
// Define CPRV_ARB_RR_EN for round-robin on ties; default is fixed D-over-I priority.
module cprv_mem_arbiter
  import cprv_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = CPRV_DATA_WIDTH,
  parameter int unsigned OUTST_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_valid_i,
  output logic                  d_ready_o,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  input  logic                  d_w_en_i,
  output logic                  d_rvalid_o,
  input  logic                  d_rready_i,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  input  logic                  i_valid_i,
  output logic                  i_ready_o,
  input  logic [DATA_WIDTH-1:0] i_addr_i,
  output logic                  i_rvalid_o,
  input  logic                  i_rready_i,
  output logic [DATA_WIDTH-1:0] i_rdata_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_addr_o,
  output logic [DATA_WIDTH-1:0] m_wdata_o,
  output logic                  m_w_en_o,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  output logic                  resp_err_o
);

  arb_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  w_en_q, w_en_d;
  logic                  resp_err_q, resp_err_d;

  logic    cke, accept, grant_d, grant_i;
  logic    fifo_full, fifo_empty, fifo_pop;
  req_id_t fifo_head, push_id;

`ifdef CPRV_ARB_RR_EN
  req_id_t last_grant_q, last_grant_d;

  assign grant_d      = d_valid_i && (!i_valid_i || (last_grant_q == REQ_I));
  assign last_grant_d = accept ? push_id : last_grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= REQ_I;
    else     last_grant_q <= last_grant_d;
  end
`else
  assign grant_d = d_valid_i;
`endif

  assign grant_i = i_valid_i && !grant_d;
  assign push_id = grant_d ? REQ_D : REQ_I;

  // A pop in the same cycle does not free a slot for acceptance.
  assign cke       = !m_valid_o || m_ready_i;
  assign accept    = cke && !fifo_full && (d_valid_i || i_valid_i);
  assign d_ready_o = accept && grant_d;
  assign i_ready_o = accept && grant_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    w_en_d  = w_en_q;
    if (accept) begin
      state_d = ARB_BUSY;
      if (grant_d) begin
        addr_d  = d_addr_i;
        wdata_d = d_wdata_i;
        w_en_d  = d_w_en_i;
      end else begin
        addr_d  = i_addr_i;
        wdata_d = '0;
        w_en_d  = 1'b0;
      end
    end else if (cke) begin
      state_d = ARB_IDLE;
    end
  end

  assign m_valid_o = (state_q == ARB_BUSY);
  assign m_addr_o  = addr_q;
  assign m_wdata_o = wdata_q;
  assign m_w_en_o  = w_en_q;

  // With nothing outstanding, stray responses are drained and flagged.
  assign m_rready_o = fifo_empty ? 1'b1 :
                      ((fifo_head == REQ_D) ? d_rready_i : i_rready_i);
  assign d_rvalid_o = m_rvalid_i && !fifo_empty && (fifo_head == REQ_D);
  assign i_rvalid_o = m_rvalid_i && !fifo_empty && (fifo_head == REQ_I);
  assign d_rdata_o  = m_rdata_i;
  assign i_rdata_o  = m_rdata_i;
  assign fifo_pop   = m_rvalid_i && m_rready_o && !fifo_empty;
  assign resp_err_d = resp_err_q || (m_rvalid_i && fifo_empty);
  assign resp_err_o = resp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      w_en_q     <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      w_en_q     <= w_en_d;
      resp_err_q <= resp_err_d;
    end
  end

  cprv_arb_id_fifo #(
    .DEPTH (OUTST_DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (accept),
    .push_id_i (push_id),
    .pop_i     (fifo_pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (fifo_head)
  );

endmodule

// File: tb/tb_cprv_mem_arbiter.sv
// Directed bench for cprv_mem_arbiter (OUTST_DEPTH=2) with hand-computed expectations.
module tb_cprv_mem_arbiter;

  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_valid_i, d_ready_o, d_w_en_i, d_rvalid_o, d_rready_i;
  logic [DW-1:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic          i_valid_i, i_ready_o, i_rvalid_o, i_rready_i;
  logic [DW-1:0] i_addr_i, i_rdata_o;
  logic          m_valid_o, m_ready_i, m_w_en_o, m_rvalid_i, m_rready_o;
  logic [DW-1:0] m_addr_o, m_wdata_o, m_rdata_i;
  logic          resp_err_o;

  int chk_cnt = 0;
  int err_cnt = 0;
  bit rr_mode;

  always #5 clk = ~clk;

  cprv_mem_arbiter #(
    .DATA_WIDTH  (DW),
    .OUTST_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .d_valid_i  (d_valid_i),
    .d_ready_o  (d_ready_o),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_w_en_i   (d_w_en_i),
    .d_rvalid_o (d_rvalid_o),
    .d_rready_i (d_rready_i),
    .d_rdata_o  (d_rdata_o),
    .i_valid_i  (i_valid_i),
    .i_ready_o  (i_ready_o),
    .i_addr_i   (i_addr_i),
    .i_rvalid_o (i_rvalid_o),
    .i_rready_i (i_rready_i),
    .i_rdata_o  (i_rdata_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_addr_o   (m_addr_o),
    .m_wdata_o  (m_wdata_o),
    .m_w_en_o   (m_w_en_o),
    .m_rvalid_i (m_rvalid_i),
    .m_rready_o (m_rready_o),
    .m_rdata_i  (m_rdata_i),
    .resp_err_o (resp_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef CPRV_ARB_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    rst = 1'b1;
    d_valid_i = 0; d_addr_i = '0; d_wdata_i = '0; d_w_en_i = 0; d_rready_i = 0;
    i_valid_i = 0; i_addr_i = '0; i_rready_i = 0;
    m_ready_i = 0; m_rvalid_i = 0; m_rdata_i = '0;
    #2;
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_addr", m_addr_o, 0);
    chk("rst_m_wdata", m_wdata_o, 0);
    chk("rst_m_w_en", m_w_en_o, 0);
    chk("rst_resp_err", resp_err_o, 0);
    chk("rst_d_ready", d_ready_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    tick;

    // Both requesters held valid; responses pop one per cycle so the FIFO never fills.
    d_valid_i = 1; d_addr_i = 64'h10; i_valid_i = 1; i_addr_i = 64'h20;
    m_ready_i = 1; d_rready_i = 1; i_rready_i = 1;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      m_rvalid_i = (k > 0);
      exp_d = rr_mode ? ((k % 2) == 0) : 1'b1;
      #1;
      chk("arb_d_ready", d_ready_o, exp_d);
      chk("arb_i_ready", i_ready_o, !exp_d);
      tick;
    end
    d_valid_i = 0; i_valid_i = 0; m_rvalid_i = 1;
    tick;
    m_rvalid_i = 0;
    tick;

    // Tie: D first, then I; FIFO (depth 2) then full.
    d_valid_i = 1; d_addr_i = 64'h200; d_w_en_i = 0; d_wdata_i = 64'h77;
    i_valid_i = 1; i_addr_i = 64'h300;
    #1;
    chk("tie_d_ready", d_ready_o, 1);
    chk("tie_i_ready", i_ready_o, 0);
    tick;
    d_valid_i = 0;
    #1;
    chk("tie2_i_ready", i_ready_o, 1);
    chk("tie2_d_ready", d_ready_o, 0);
    chk("tie2_m_addr", m_addr_o, 64'h200);
    tick;
    i_valid_i = 0;
    #1;
    chk("i_slot_addr", m_addr_o, 64'h300);
    chk("i_slot_w_en", m_w_en_o, 0);
    chk("i_slot_wdata", m_wdata_o, 0);
    d_valid_i = 1; d_addr_i = 64'h400; d_w_en_i = 1; d_wdata_i = 64'hBEEF;
    #1;
    chk("full_stall", d_ready_o, 0);
    tick;
    m_rvalid_i = 1; m_rdata_i = 64'hAAAA; d_rready_i = 1;
    #1;
    chk("pop_d_rvalid", d_rvalid_o, 1);
    chk("no_pop_credit", d_ready_o, 0);
    tick;
    m_rvalid_i = 0;
    #1;
    chk("after_pop_ready", d_ready_o, 1);
    tick;
    d_valid_i = 0;
    #1;
    chk("third_m_valid", m_valid_o, 1);
    chk("third_m_addr", m_addr_o, 64'h400);
    m_rvalid_i = 1;
    #1;
    chk("drain_i_rvalid", i_rvalid_o, 1);
    chk("drain_d_rvalid0", d_rvalid_o, 0);
    tick;
    chk("drain_d_rvalid", d_rvalid_o, 1);
    tick;
    m_rvalid_i = 0;

    // Single D store.
    d_valid_i = 1; d_addr_i = 64'h100; d_wdata_i = 64'hDEAD; d_w_en_i = 1;
    #1;
    chk("st_d_ready", d_ready_o, 1);
    tick;
    d_valid_i = 0;
    #1;
    chk("st_m_valid", m_valid_o, 1);
    chk("st_m_addr", m_addr_o, 64'h100);
    chk("st_m_wdata", m_wdata_o, 64'hDEAD);
    chk("st_m_w_en", m_w_en_o, 1);
    tick;
    m_rvalid_i = 1; m_rdata_i = 64'h5555;
    #1;
    chk("st_d_rvalid", d_rvalid_o, 1);
    chk("st_i_rvalid", i_rvalid_o, 0);
    chk("st_d_rdata", d_rdata_o, 64'h5555);
    tick;
    m_rvalid_i = 0;

    // Memory back-pressure with I pending.
    m_ready_i = 0; d_valid_i = 1; d_addr_i = 64'h500; d_w_en_i = 0;
    tick;
    d_valid_i = 0; i_valid_i = 1; i_addr_i = 64'h600;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_m_valid", m_valid_o, 1);
      chk("bp_m_addr", m_addr_o, 64'h500);
      chk("bp_d_ready", d_ready_o, 0);
      chk("bp_i_ready", i_ready_o, 0);
      tick;
    end
    m_ready_i = 1;
    #1;
    chk("bp_release_i_ready", i_ready_o, 1);
    tick;
    i_valid_i = 0;
    #1;
    chk("bp_i_addr", m_addr_o, 64'h600);
    tick;
    m_rvalid_i = 1;
    #1;
    chk("bp_resp_d", d_rvalid_o, 1);
    tick;
    chk("bp_resp_i", i_rvalid_o, 1);
    tick;
    m_rvalid_i = 0;

    // Response back-pressure from I, then in-order routing.
    i_valid_i = 1; i_addr_i = 64'h40;
    tick;
    i_valid_i = 0; d_valid_i = 1; d_addr_i = 64'h80;
    #1;
    chk("rr_d_ready", d_ready_o, 1);
    tick;
    d_valid_i = 0;
    tick;
    m_rvalid_i = 1; m_rdata_i = 64'h1111; i_rready_i = 0; d_rready_i = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("hold_m_rready", m_rready_o, 0);
      chk("hold_i_rvalid", i_rvalid_o, 1);
      chk("hold_d_rvalid", d_rvalid_o, 0);
      tick;
    end
    i_rready_i = 1;
    #1;
    chk("rel_m_rready", m_rready_o, 1);
    chk("rel_i_rdata", i_rdata_o, 64'h1111);
    tick;
    m_rdata_i = 64'h2222;
    #1;
    chk("ord_d_rvalid", d_rvalid_o, 1);
    chk("ord_i_rvalid", i_rvalid_o, 0);
    chk("ord_d_rdata", d_rdata_o, 64'h2222);
    tick;
    m_rvalid_i = 0;
    #1;
    chk("no_err_yet", resp_err_o, 0);

    // Reset while BUSY, then a stray response.
    m_ready_i = 0; d_valid_i = 1; d_addr_i = 64'h900;
    tick;
    d_valid_i = 0;
    #1;
    chk("pre_rst_m_valid", m_valid_o, 1);
    rst = 1;
    #1;
    chk("async_rst_m_valid", m_valid_o, 0);
    chk("async_rst_m_addr", m_addr_o, 0);
    tick;
    rst = 0;
    tick;
    m_rvalid_i = 1;
    #1;
    chk("stray_m_rready", m_rready_o, 1);
    chk("stray_d_rvalid", d_rvalid_o, 0);
    chk("stray_i_rvalid", i_rvalid_o, 0);
    chk("stray_err_pre", resp_err_o, 0);
    tick;
    m_rvalid_i = 0;
    #1;
    chk("stray_err_set", resp_err_o, 1);
    tick;
    chk("stray_err_sticky", resp_err_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cprv_mem_arbiter.md
Name: cprv_mem_arbiter

Overview:
- Shares one unified memory port between two requesters: the mem stage data port (D) and the fetch stage instruction port (I).
- Accepts requests from both sides over valid/ready, issues them to the memory one at a time through a registered request slot, and routes each in-order response back to the requester that issued it.
- Sits between the mem/fetch stages and the single-port memory model or bus bridge.

Parameters:
DATA_WIDTH, 64, width of address, write data and read data
OUTST_DEPTH, 4, maximum number of outstanding requests (depth of the response-ID FIFO); power of two, ≥2

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
d_valid_i  in  1  D request valid
d_ready_o  out  1  D request accepted
d_addr_i  in  DATA_WIDTH  D address
d_wdata_i  in  DATA_WIDTH  D store data
d_w_en_i  in  1  D write enable (1 = store)
d_rvalid_o  out  1  D response valid
d_rready_i  in  1  D response ready
d_rdata_o  out  DATA_WIDTH  D load data
i_valid_i  in  1  I request valid
i_ready_o  out  1  I request accepted
i_addr_i  in  DATA_WIDTH  I fetch address
i_rvalid_o  out  1  I response valid
i_rready_i  in  1  I response ready
i_rdata_o  out  DATA_WIDTH  I fetch data
m_valid_o  out  1  memory request valid
m_ready_i  in  1  memory request accepted
m_addr_o  out  DATA_WIDTH  memory address
m_wdata_o  out  DATA_WIDTH  memory write data
m_w_en_o  out  1  memory write enable
m_rvalid_i  in  1  memory response valid (every request, including stores, gets exactly one response)
m_rready_o  out  1  memory response ready
m_rdata_i  in  DATA_WIDTH  memory read data
resp_err_o  out  1  sticky: response received with no outstanding request

Behaviour:
- Reset (async, immediate):
  - m_valid_o=0; m_addr_o/m_wdata_o/m_w_en_o=0.
  - FIFO empty; resp_err_o=0; last_grant=I, so D wins the first RR tie.
- Request slot:
  - cke = ~m_valid_o | m_ready_i.
  - accept = cke & ~fifo_full & winner_valid.
  - No pop credit is taken in the same cycle: a full FIFO blocks acceptance even if a response pops that cycle.
- Grant (combinational):
  - Fixed priority: D over I.
  - d_ready_o = accept & grant_d; i_ready_o = accept & grant_i. Never both high.
- On accept:
  - Slot registers the winner's addr, wdata and w_en (I: wdata=0, w_en=0).
  - m_valid_o=1 next cycle; winner ID pushed into the FIFO.
  - Request latency: 1 cycle from handshake to m_valid_o.
- On cke & ~accept: m_valid_o<=0.
- While m_valid_o & ~m_ready_i: all m_* outputs held stable; both requester ready outputs are low.
- States:
  - IDLE (m_valid_o=0).
  - BUSY (m_valid_o=1). BUSY→BUSY when m_ready_i & accept; BUSY→IDLE when m_ready_i & ~accept; BUSY holds when ~m_ready_i.
- Response routing:
  - FIFO head selects the target requester.
  - d_rvalid_o = m_rvalid_i & ~empty & head==D; same for I.
  - m_rready_o = selected requester's rready.
  - m_rdata_i is fanned out unregistered to both rdata outputs.
  - Pop on m_rvalid_i & m_rready_o & ~empty.
- Push and pop in the same cycle: count unchanged; ordering is preserved.
- m_rvalid_i while empty: m_rready_o=1 (drain), no requester rvalid, resp_err_o<=1 (held until reset).
- Reset mid-operation: pending slot and FIFO contents are discarded; the memory side is expected to be reset together.

Optional Feature:
CPRV_ARB_RR_EN
- Defined: round-robin. When both requesters are valid, grant the one not equal to last_grant. last_grant updates on every accept. A single valid requester always wins.
- Undefined: fixed D-over-I priority; last_grant register removed.

Decomposition:
- Package cprv_arb_pkg: typedef enum {REQ_D, REQ_I} req_id_t; typedef enum {ARB_IDLE, ARB_BUSY} arb_state_t.
- DATA_WIDTH comes from the shared core package.
- Sub-module cprv_arb_id_fifo:
  - Synchronous push/pop FIFO of req_id_t, depth OUTST_DEPTH, async active-high reset.
  - Outputs full, empty and head.
  - Pointer width $clog2(OUTST_DEPTH)+1 for full/empty discrimination.

Test Plan:
- D store addr 0x100, wdata 0xDEAD, m_ready_i=1 → next cycle m_valid_o=1, m_addr_o=0x100, m_w_en_o=1. A later m_rvalid_i raises only d_rvalid_o.
- D and I both valid, same cycle, fixed priority → d_ready_o=1 first, i_ready_o=1 next cycle. With CPRV_ARB_RR_EN and both held valid, grants alternate D,I,D,I.
- m_ready_i low 3 cycles with I pending → m_addr_o/m_valid_o stable, d_ready_o=i_ready_o=0 throughout. I is accepted the cycle m_ready_i rises.
- OUTST_DEPTH=2, two accepted requests, no responses → third request stalled with ready=0. One response popped → third request accepted the following cycle.
- Issue I (0x40) then D (0x80); responses 0x1111, 0x2222; hold i_rready_i=0 for 2 cycles → m_rready_o=0 for those cycles. I gets 0x1111, then D gets 0x2222.
- Assert rst while BUSY → m_valid_o=0 immediately; FIFO empty. A stray m_rvalid_i after reset sets resp_err_o=1.
